// File: rtl/prog_fetch_ctrl.sv
// Instruction-fetch sequencer for the picoMIPS program memory.
// Owns the fetch PC, registers fetched words into a valid/ready instruction
// register, applies absolute/relative branches with a one-bubble flush and
// supports halt/resume.
module prog_fetch_ctrl #(
    parameter int unsigned Psize = 5,
    parameter int unsigned Isize = 20,
    parameter int unsigned Csize = 8
) (
    input  logic             clk,
    input  logic             nReset,
    output logic [Psize-1:0] address,
    input  logic [Isize-1:0] I,
    output logic [Isize-1:0] ir,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [Psize-1:0] pc,
    input  logic             br_abs,
    input  logic             br_rel,
    input  logic [Psize-1:0] br_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted,
    output logic [Csize-1:0] retired
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             take_branch;
    logic             load;
    logic [Psize-1:0] target;

    // Next-state logic: halt_req wins over resume.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt_req) state_next = HALT;
            HALT:    if (resume && !halt_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State register; halted mirrors the registered state.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= (state_next == HALT);
        end
    end

    // Handshake, branch target and load qualification.
    always_comb begin
        accept      = 1'b0;
        take_branch = 1'b0;
        load        = 1'b0;
        target      = br_target;
        accept      = ir_valid && ir_ready;
        take_branch = accept && (br_abs || br_rel);
        if (!br_abs) begin
            // Offset wraps modulo the address space, so sign extension is implicit.
            target = pc + Psize'(1) + br_target;
        end
        load = (state == RUN) && (!ir_valid || ir_ready) && !take_branch;
    end

    // Fetch PC and instruction register; a taken branch discards the word at the old fpc.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            address  <= '0;
            ir       <= '0;
            pc       <= '0;
            ir_valid <= 1'b0;
        end else if (take_branch) begin
            address  <= target;
            ir_valid <= 1'b0;
        end else if (load) begin
            ir       <= I;
            pc       <= address;
            ir_valid <= 1'b1;
            address  <= address + Psize'(1);
        end else if (accept) begin
            ir_valid <= 1'b0;
        end
    end

    // Saturating count of accepted instructions.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            retired <= '0;
        end else if (accept && (retired != {Csize{1'b1}})) begin
            retired <= retired + Csize'(1);
        end
    end

endmodule
